// File: rtl/enc_seq_pkg.sv
// rtl/enc_seq_pkg.sv - shared width codes, FSM states, masks and alignment helpers for the encoder job sequencer
package enc_seq_pkg;

  localparam logic [1:0] WC_SMALL   = 2'b00;
  localparam logic [1:0] WC_MEDIUM  = 2'b01;
  localparam logic [1:0] WC_LARGE   = 2'b10;
  localparam logic [1:0] WC_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [31:0] MASK_SMALL  = 32'h0000_00FF;
  localparam logic [31:0] MASK_MEDIUM = 32'h0000_FFFF;
  localparam logic [31:0] MASK_LARGE  = 32'hFFFF_FFFF;

  localparam int OFF_SMALL  = 28;
  localparam int OFF_MEDIUM = 21;
  localparam int OFF_LARGE  = 6;

  // Left-justify the payload into the encoder word; bits above the size are dropped.
  function automatic logic [31:0] align_data(input logic [25:0] d, input logic [1:0] w);
    logic [31:0] a;
    a = '0;
    case (w)
      WC_SMALL:  a = 32'(d[3:0]) << OFF_SMALL;
      WC_MEDIUM: a = 32'(d[10:0]) << OFF_MEDIUM;
      WC_LARGE:  a = 32'(d[25:0]) << OFF_LARGE;
      default:   a = '0;
    endcase
    return a;
  endfunction

  function automatic logic [31:0] width_mask(input logic [1:0] w);
    logic [31:0] m;
    m = '0;
    case (w)
      WC_SMALL:  m = MASK_SMALL;
      WC_MEDIUM: m = MASK_MEDIUM;
      WC_LARGE:  m = MASK_LARGE;
      default:   m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter, pointer advances only on accept
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = valid;
    if (valid[0] && valid[1]) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Reset to 1 so requester 0 wins the first contested round.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/enc_job_sequencer.sv
// rtl/enc_job_sequencer.sv - arbitrates two requesters onto the shared parity encoder and returns masked codewords
module enc_job_sequencer
  import enc_seq_pkg::*;
#(
  parameter int AMBA_WORD = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [25:0]          req0_data,
  input  logic [1:0]           req0_width,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [25:0]          req1_data,
  input  logic [1:0]           req1_width,
  output logic                 enc_small,
  output logic                 enc_medium,
  output logic                 enc_large,
  output logic [AMBA_WORD-1:0] enc_data_in,
  input  logic [AMBA_WORD-1:0] enc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AMBA_WORD-1:0] out_codeword,
  output logic [1:0]           out_width,
  output logic                 out_src,
  output logic                 out_err,
  output logic [CNT_W-1:0]     job_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  state_t      state;
  logic [1:0]  grant;
  logic [1:0]  ready;
  logic        accept;
  logic [25:0] sel_data;
  logic [1:0]  sel_width;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Grants are only honoured in IDLE; requests simply wait otherwise.
  assign ready      = (state == ST_IDLE) ? grant : 2'b00;
  assign accept     = |ready;
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign sel_data   = ready[1] ? req1_data  : req0_data;
  assign sel_width  = ready[1] ? req1_width : req0_width;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      enc_small    <= 1'b0;
      enc_medium   <= 1'b0;
      enc_large    <= 1'b0;
      enc_data_in  <= '0;
      out_valid    <= 1'b0;
      out_codeword <= '0;
      out_width    <= 2'b00;
      out_src      <= 1'b0;
      out_err      <= 1'b0;
      job_cnt      <= '0;
      err_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            out_width <= sel_width;
            out_src   <= ready[1];
            if (sel_width == WC_ILLEGAL) begin
              out_err      <= 1'b1;
              out_codeword <= '0;
              out_valid    <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
              state <= ST_HOLD;
            end else begin
              // Encoder inputs are registered here so they are live throughout ISSUE and WAIT.
              out_err     <= 1'b0;
              enc_data_in <= align_data(sel_data, sel_width);
              enc_small   <= (sel_width == WC_SMALL);
              enc_medium  <= (sel_width == WC_MEDIUM);
              enc_large   <= (sel_width == WC_LARGE);
              state       <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          out_codeword <= enc_out & width_mask(out_width);
          out_valid    <= 1'b1;
          enc_small    <= 1'b0;
          enc_medium   <= 1'b0;
          enc_large    <= 1'b0;
          enc_data_in  <= '0;
          if (job_cnt != '1) job_cnt <= job_cnt + CNT_W'(1);
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enc_job_sequencer.sv
// tb/tb_enc_job_sequencer.sv - self-checking bench with encoder model and output scoreboard
module tb_enc_job_sequencer;
  import enc_seq_pkg::*;

  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [25:0] req0_data = '0, req1_data = '0;
  logic [1:0]  req0_width = '0, req1_width = '0;
  logic        enc_small, enc_medium, enc_large;
  logic [31:0] enc_data_in;
  logic [31:0] enc_out = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_codeword;
  logic [1:0]  out_width;
  logic        out_src, out_err;
  logic [CNT_W-1:0] job_cnt, err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit watch_enc_zero = 1'b0;

  typedef struct {
    logic [31:0] cw;
    logic [1:0]  w;
    logic        src;
    logic        err;
  } exp_t;

  typedef struct {
    logic        src;
    logic [25:0] data;
    logic [1:0]  w;
    logic [31:0] cw;
  } vec_t;

  exp_t sb[$];
  vec_t vec[7];

  enc_job_sequencer #(.AMBA_WORD(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_width(req0_width),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_width(req1_width),
    .enc_small(enc_small), .enc_medium(enc_medium), .enc_large(enc_large),
    .enc_data_in(enc_data_in), .enc_out(enc_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_codeword(out_codeword),
    .out_width(out_width), .out_src(out_src), .out_err(out_err),
    .job_cnt(job_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Encoder stand-in: rotated word plus a parity bit, with junk above the codeword so masking matters.
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
  endfunction

  always @(posedge clk) begin
    if (enc_small)       enc_out <= rotr(enc_data_in, 24) | 32'(^enc_data_in) | 32'hA5A5_A500;
    else if (enc_medium) enc_out <= rotr(enc_data_in, 16) | 32'(^enc_data_in) | 32'h5A5A_0000;
    else if (enc_large)  enc_out <= enc_data_in | 32'(^enc_data_in);
    else                 enc_out <= 32'h0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("enc_onehot", 32'(int'(enc_small) + int'(enc_medium) + int'(enc_large) <= 1), 32'd1);
      if (watch_enc_zero)
        check("enc_idle_zero", {enc_small, enc_medium, enc_large, enc_data_in}, '0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_output", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_codeword", out_codeword, e.cw);
          check("sb_width", 32'(out_width), 32'(e.w));
          check("sb_src", 32'(out_src), 32'(e.src));
          check("sb_err", 32'(out_err), 32'(e.err));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic run_job(input logic src, input logic [25:0] d, input logic [1:0] w,
                         input exp_t e, input int exp_lat);
    bit ok;
    int lat;
    sb.push_back(e);
    @(posedge clk); #1;
    if (src) begin req1_valid = 1'b1; req1_data = d; req1_width = w; end
    else     begin req0_valid = 1'b1; req0_data = d; req0_width = w; end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (src ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
    check("latency", 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{1'b0, 26'h000000B, WC_SMALL,   32'h0000_00B1};
    vec[1] = '{1'b1, 26'h00007FF, WC_MEDIUM,  32'h0000_FFE1};
    vec[2] = '{1'b0, 26'h3FFFFFF, WC_LARGE,   32'hFFFF_FFC0};
    vec[3] = '{1'b1, 26'h0000123, WC_ILLEGAL, 32'h0000_0000};
    vec[4] = '{1'b0, 26'h3FFFFF5, WC_SMALL,   32'h0000_0050};
    vec[5] = '{1'b1, 26'h0000001, WC_MEDIUM,  32'h0000_0021};
    vec[6] = '{1'b0, 26'h0000001, WC_LARGE,   32'h0000_0041};

    do_reset();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_enc_sel", {29'd0, enc_small, enc_medium, enc_large}, 0);
    check("rst_enc_data", enc_data_in, 0);
    check("rst_codeword", out_codeword, 0);
    check("rst_meta", {28'd0, out_width, out_src, out_err}, 0);
    check("rst_counters", {24'd0, job_cnt, err_cnt}, 0);
    check("rst_ready", {30'd0, req1_ready, req0_ready}, 0);

    // Single small job with cycle-by-cycle encoder checks.
    sb.push_back('{32'h0000_00B1, WC_SMALL, 1'b0, 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 26'hB; req0_width = WC_SMALL;
    @(negedge clk);
    check("t1_req0_ready", 32'(req0_ready), 1);
    check("t1_req1_ready", 32'(req1_ready), 0);
    @(posedge clk); #1 req0_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t1_enc_sel", {29'd0, enc_small, enc_medium, enc_large}, 32'd4);
      check("t1_enc_data", enc_data_in, 32'hB000_0000);
      check("t1_out_valid_early", 32'(out_valid), 0);
    end
    @(negedge clk);
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_enc_cleared", {29'd0, enc_small, enc_medium, enc_large}, 0);
    check("t1_job_cnt", 32'(job_cnt), 1);

    for (int i = 0; i < 7; i++) begin
      run_job(vec[i].src, vec[i].data, vec[i].w,
              '{vec[i].cw, vec[i].w, vec[i].src, (vec[i].w == WC_ILLEGAL)},
              (vec[i].w == WC_ILLEGAL) ? 1 : 3);
    end
    drain("table_drain");

    // Both requesters held valid: grants must alternate starting at requester 0.
    do_reset();
    for (int k = 0; k < 4; k++) sb.push_back('{32'h0, WC_LARGE, 1'(k % 2), 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = '0; req0_width = WC_LARGE;
    req1_valid = 1'b1; req1_data = '0; req1_width = WC_LARGE;
    begin
      int acc;
      acc = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        check("t2_ready_excl", 32'(req0_ready & req1_ready), 0);
        if (req0_ready || req1_ready) acc++;
        if (acc == 4) break;
      end
      check("t2_accepts", 32'(acc), 4);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t2_drain");

    // Illegal width from requester 1: encoder never driven.
    watch_enc_zero = 1'b1;
    run_job(1'b1, 26'h0AB, WC_ILLEGAL, '{32'h0, WC_ILLEGAL, 1'b1, 1'b1}, 1);
    drain("t3_drain");
    watch_enc_zero = 1'b0;
    check("t3_err_cnt", 32'(err_cnt), 1);

    // Backpressure: result stays put and nobody is granted while held.
    out_ready = 1'b0;
    run_job(1'b1, 26'h7FF, WC_MEDIUM, '{32'h0000_FFE1, WC_MEDIUM, 1'b1, 1'b0}, 3);
    sb.push_back('{32'h0000_00B1, WC_SMALL, 1'b0, 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 26'hB; req0_width = WC_SMALL;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(out_valid), 1);
      check("t4_hold_cw", out_codeword, 32'h0000_FFE1);
      check("t4_hold_src", 32'(out_src), 1);
      check("t4_no_ready", {30'd0, req1_ready, req0_ready}, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    check("t4_handshake_no_ready", 32'(req0_ready), 0);
    @(negedge clk);
    check("t4_released_valid", 32'(out_valid), 0);
    check("t4_next_grant", 32'(req0_ready), 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    drain("t4_drain");

    // Reset during WAIT aborts the job and restores the arbiter pointer.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 26'h3FFFFFF; req0_width = WC_LARGE;
    @(negedge clk);
    check("t5_accept", 32'(req0_ready), 1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_enc", {enc_small, enc_medium, enc_large, enc_data_in}, 0);
    check("t5_counters", {24'd0, job_cnt, err_cnt}, 0);
    sb.push_back('{32'h0000_00B1, WC_SMALL, 1'b0, 1'b0});
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 26'hB; req0_width = WC_SMALL;
    req1_valid = 1'b1; req1_data = 26'hB; req1_width = WC_SMALL;
    @(negedge clk);
    check("t5_grant_req0", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain("t5_drain");

    // Job counter saturation.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      logic [3:0] d4;
      d4 = 4'(k);
      run_job(1'b0, 26'(k), WC_SMALL, '{{24'h0, d4, 3'b000, ^d4}, WC_SMALL, 1'b0, 1'b0}, 3);
      if (k == 14) check("t6_cnt_full", 32'(job_cnt), 32'hF);
    end
    drain("t6_drain");
    check("t6_cnt_saturated", 32'(job_cnt), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_job_sequencer.md
Name: enc_job_sequencer

Overview:
- Front-end controller for the shared parity Encoder datapath (32-bit word; Small/Medium/Large one-hot size selects; one-cycle registered output, right-rotated codeword).
- Two requesters submit raw data plus a width code. The block arbitrates round-robin, aligns and zero-pads the data, drives the encoder, captures the result, masks it to the codeword width and returns it on a valid/ready output port.
- Sits between the bus-side register/DMA logic and the Encoder instance.

Parameters:
AMBA_WORD, 32, encoder word width; only 32 is supported.
CNT_W, 16, width of the saturating job and error counters.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has a job
req0_ready  out  1  requester 0 job accepted this cycle
req0_data  in  26  right-justified raw data
req0_width  in  2  00 small, 01 medium, 10 large, 11 illegal
req1_valid/req1_ready/req1_data/req1_width  same as requester 0
enc_small, enc_medium, enc_large  out  1 each  encoder size selects, one-hot or all zero
enc_data_in  out  32  aligned encoder input
enc_out  in  32  encoder registered output
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_codeword  out  32  masked codeword
out_width  out  2  width code of the job
out_src  out  1  requester index of the job
out_err  out  1  job had an illegal width
job_cnt  out  CNT_W  legal jobs completed, saturating
err_cnt  out  CNT_W  illegal jobs, saturating

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset state: FSM=IDLE; all outputs 0; last_grant=1, so requester 0 wins first. rst asserted in any state aborts the job; the captured result is discarded.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - grant = requester that is valid; if both are valid, grant the one != last_grant.
  - req*_ready=1 combinationally for the granted requester only; the other stays 0.
  - On accept: latch data, width and src; update last_grant.
  - Legal width -> ISSUE. Width 11 -> HOLD with out_err=1, out_codeword=0, err_cnt++; the encoder is never driven.
- ISSUE:
  - Registered enc_* are driven from the latched job.
  - small: enc_data_in[31:28]=data[3:0].
  - medium: [31:21]=data[10:0].
  - large: [31:6]=data[25:0].
  - All other bits are 0; unused data bits are ignored.
  - Next state WAIT.
- WAIT:
  - enc_* are held unchanged; enc_out is valid.
  - Capture out_codeword = enc_out AND mask: small 0x000000FF, medium 0x0000FFFF, large 0xFFFFFFFF.
  - job_cnt++; next state HOLD.
- HOLD:
  - out_valid=1. out_codeword, out_width, out_src and out_err are stable until handshake.
  - enc_* return to 0.
  - On out_valid&out_ready -> IDLE, out_valid=0 next cycle.
  - No new accept occurs while in HOLD; requests wait, and the grant is evaluated only in IDLE.
- Latency: accept at cycle T -> out_valid at T+3 (legal) or T+1 (illegal). Throughput is at most 1 job per 4 cycles.
- enc_small/medium/large are never more than one high.
- Counters saturate at all-ones and never wrap.
- Requester data/width changing while its ready=0 has no effect.

Decomposition:
- Package enc_seq_pkg:
  - width codes WC_SMALL=2'b00, WC_MEDIUM=2'b01, WC_LARGE=2'b10, WC_ILLEGAL=2'b11;
  - state encoding;
  - masks MASK_SMALL, MASK_MEDIUM, MASK_LARGE;
  - data alignment offsets 28/21/6.
- Sub-module rr_arb2: 2-input round-robin arbiter (valid in, one-hot grant out, pointer update on accept).
- The Encoder is instantiated by the parent, not inside this block.

Test Plan:
1. Reset then req0 small data=4'hB -> req0_ready at T; enc_small=1, enc_data_in=0xB0000000 during T+1..T+2; out_valid at T+3 with out_codeword=0x000000B1, out_src=0, out_err=0; job_cnt=1.
2. req0 and req1 held valid, large data=0 -> grants alternate 0,1,0,1; each out_codeword=0; out_src toggles.
3. req1 width=11 -> out_valid at T+1, out_err=1, out_codeword=0, err_cnt=1; enc_* stay 0 throughout.
4. Medium job with out_ready=0 for 10 cycles -> outputs stable; neither req*_ready asserts; completes one cycle after out_ready=1.
5. rst=1 during WAIT -> next cycle state IDLE, out_valid=0, enc_*=0, counters=0; a subsequent request is granted to req0.
6. Force job_cnt to all-ones, run one more legal job -> job_cnt stays 0xFFFF.
